ascon_reg_driver: RTL and testbench



---
 rtl/ascon_reg_driver.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ascon_reg_driver.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_reg_driver.sv
// ascon_reg_driver: register-bus initiator for the ASCON accelerator.
// On an accepted command it writes the 320-bit state as ten 32-bit words,
// launches the permutation, polls STATUS until done (bounded by POLL_LIMIT)
// and reads the ten state words back.
// Optional build macro ASCON_DRV_CYCLE_CNT_EN adds cycles_o, the number of
// cycles spent polling for the most recent run.

package ascon_reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module ascon_reg_driver
  import ascon_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter int unsigned DONE_BIT   = 1,
  parameter int unsigned START_BIT  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [4:0][63:0]     state_i,
  output logic [4:0][63:0]     state_o,
  output logic                 done_o,
  output logic                 error_o,
  output reg_req_t             reg_req_o,
  input  reg_rsp_t             reg_rsp_i
`ifdef ASCON_DRV_CYCLE_CNT_EN
  ,
  output logic [31:0]          cycles_o
`endif
);

  localparam int unsigned PCW       = $clog2(POLL_LIMIT + 1);
  localparam logic [3:0]  LAST_WORD = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    WR_STATE,
    WR_START,
    POLL,
    RD_STATE,
    FIN
  } fsm_e;

  fsm_e            state_q,     state_d;
  logic [3:0]      k_q,         k_d;
  logic [PCW-1:0]  poll_cnt_q,  poll_cnt_d;
  logic [4:0][63:0] wr_state_q, wr_state_d;
  logic [4:0][63:0] rd_state_q, rd_state_d;
  reg_req_t        req_q,       req_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            done_q,      done_d;
  logic            error_q,     error_d;

  logic            xfer_done;
  logic [PCW-1:0]  poll_inc;

  // Byte address of state word k (k = 0..9).
  function automatic logic [31:0] word_addr(input logic [3:0] k);
    return BASE_ADDR + 32'h4 + {26'd0, k, 2'b00};
  endfunction

  // Word 2j is the low half of lane j, word 2j+1 the high half.
  function automatic logic [31:0] word_sel(input logic [4:0][63:0] s,
                                           input logic [3:0]       k);
    logic [63:0] lane;
    lane = s[k[3:1]];
    return k[0] ? lane[63:32] : lane[31:0];
  endfunction

  assign xfer_done = req_q.valid && reg_rsp_i.ready;
  assign poll_inc  = poll_cnt_q + 1'b1;

  // Sequencer next-state: walks write, launch, poll and readback phases.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    poll_cnt_d = poll_cnt_q;
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          wr_state_d = state_i;
          k_d        = '0;
          state_d    = WR_STATE;
        end
      end

      WR_STATE: begin
        if (xfer_done) begin
          if (reg_rsp_i.error) begin
            state_d = FIN;
            error_d = 1'b1;
          end else if (k_q == LAST_WORD) begin
            state_d = WR_START;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end

      WR_START: begin
        if (xfer_done) begin
          if (reg_rsp_i.error) begin
            state_d = FIN;
            error_d = 1'b1;
          end else begin
            poll_cnt_d = '0;
            state_d    = POLL;
          end
        end
      end

      POLL: begin
        if (xfer_done) begin
          if (reg_rsp_i.error) begin
            state_d = FIN;
            error_d = 1'b1;
          end else begin
            poll_cnt_d = poll_inc;
            if (reg_rsp_i.rdata[DONE_BIT]) begin
              k_d     = '0;
              state_d = RD_STATE;
            end else if (poll_inc == PCW'(POLL_LIMIT)) begin
              state_d = FIN;
              error_d = 1'b1;
            end
          end
        end
      end

      RD_STATE: begin
        if (xfer_done) begin
          if (reg_rsp_i.error) begin
            state_d = FIN;
            error_d = 1'b1;
          end else begin
            if (k_q[0]) begin
              rd_state_d[k_q[3:1]][63:32] = reg_rsp_i.rdata;
            end else begin
              rd_state_d[k_q[3:1]][31:0] = reg_rsp_i.rdata;
            end
            if (k_q == LAST_WORD) begin
              state_d = FIN;
            end else begin
              k_d = k_q + 4'd1;
            end
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    done_d      = (state_d == FIN);
    cmd_ready_d = (state_d == IDLE);
  end

  // Bus request for the next cycle, derived from the next state so that the
  // request is registered yet a new transfer follows a completed one at once.
  always_comb begin
    req_d = '0;
    unique case (state_d)
      WR_STATE: begin
        req_d.valid = 1'b1;
        req_d.write = 1'b1;
        req_d.addr  = word_addr(k_d);
        req_d.wdata = word_sel(wr_state_d, k_d);
        req_d.wstrb = 4'hF;
      end
      WR_START: begin
        req_d.valid = 1'b1;
        req_d.write = 1'b1;
        req_d.addr  = BASE_ADDR;
        req_d.wdata = 32'h1 << START_BIT;
        req_d.wstrb = 4'hF;
      end
      POLL: begin
        req_d.valid = 1'b1;
        req_d.addr  = BASE_ADDR;
      end
      RD_STATE: begin
        req_d.valid = 1'b1;
        req_d.addr  = word_addr(k_d);
      end
      default: begin
        req_d = '0;
      end
    endcase
  end

  // Sequencer state, data registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: the 320-bit state holders are plain flops, not a RAM, so they
    // take the asynchronous reset like everything else; the reset also drops
    // the bus request immediately.
    if (!rst_n_i) begin
      state_q     <= IDLE;
      k_q         <= '0;
      poll_cnt_q  <= '0;
      wr_state_q  <= '0;
      rd_state_q  <= '0;
      req_q       <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge regardless of statement order.
      state_q     <= state_d;
      k_q         <= k_d;
      poll_cnt_q  <= poll_cnt_d;
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign state_o     = rd_state_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign reg_req_o   = req_q;

`ifdef ASCON_DRV_CYCLE_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Poll-phase cycle counter: cleared on launch, counts POLL cycles, saturates.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == WR_START && xfer_done && !reg_rsp_i.error) begin
      cycles_d = '0;
    end else if (state_q == POLL && cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Poll-phase cycle counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_ascon_reg_driver.sv
// Testbench for ascon_reg_driver: a register-slave model with optional random
// wait states and error injection, plus a transaction-level reference model
// of the expected bus traffic, result and timing for each command.
module tb_ascon_reg_driver;
  import ascon_reg_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          LIMIT   = 4;
  localparam int          DONE_B  = 1;
  localparam int          START_B = 0;

  typedef logic [4:0][63:0] st_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xfer_t;

  logic       clk_i       = 1'b0;
  logic       rst_n_i     = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  st_t        state_i     = '0;
  st_t        state_o;
  logic       done_o;
  logic       error_o;
  reg_req_t   reg_req_o;
  reg_rsp_t   reg_rsp_i   = '0;
`ifdef ASCON_DRV_CYCLE_CNT_EN
  logic [31:0] cycles_o;
`endif

  ascon_reg_driver #(
    .BASE_ADDR (BASE),
    .POLL_LIMIT(LIMIT),
    .DONE_BIT  (DONE_B),
    .START_BIT (START_B)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .state_i    (state_i),
    .state_o    (state_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .reg_req_o  (reg_req_o),
    .reg_rsp_i  (reg_rsp_i)
`ifdef ASCON_DRV_CYCLE_CNT_EN
    ,
    .cycles_o   (cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [319:0] got,
                       input logic [319:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration (written by the stimulus process).
  int          cfg_done_poll = 3;
  int          cfg_err       = -1;
  bit          wait_en       = 1'b0;
  logic [31:0] rb [10];

  // Slave observations (written only by the slave process).
  int          acc_cnt = 0, acc_cyc = 0;
  int          done_cnt = 0, done_cyc = 0, last_cpl_cyc = 0;
  int          xfer_idx = 0, polls = 0, stalls = 0, stall_run = 0;
  int          stat_cyc = 0, viol = 0;
  logic        err_seen = 1'b0;
  logic [31:0] cyc_seen = '0;
  xfer_t       log_q [$];
  bit          prev_stall = 1'b0;
  reg_req_t    prev_req = '0;

  // Register slave: answers on the falling edge, logs completed transfers.
  initial begin
    reg_rsp_t rsp;
    bit       rdy;
    int       k;
    forever begin
      @(negedge clk_i);
      if (cmd_valid_i && cmd_ready_o && rst_n_i) begin
        acc_cnt++;
        acc_cyc   = cyc;
        log_q.delete();
        xfer_idx  = 0;
        polls     = 0;
        stalls    = 0;
        stat_cyc  = 0;
        viol      = 0;
      end
      rsp       = '0;
      rsp.rdata = $urandom;
      if (reg_req_o.valid) begin
        if (prev_stall && reg_req_o != prev_req) viol++;
        if (!reg_req_o.write && reg_req_o.addr == BASE) stat_cyc++;
        rdy = 1'b1;
        if (wait_en && stall_run < 4 && $urandom_range(0, 2) == 0) rdy = 1'b0;
        if (rdy) begin
          stall_run = 0;
          if (!reg_req_o.write) begin
            if (reg_req_o.addr == BASE) begin
              polls++;
              rsp.rdata[DONE_B] = (cfg_done_poll != 0 && polls == cfg_done_poll);
            end else begin
              k = int'((reg_req_o.addr - BASE - 32'h4) >> 2);
              rsp.rdata = (k >= 0 && k < 10) ? rb[k] : 32'hDEAD_BEEF;
            end
          end
          rsp.error = (xfer_idx == cfg_err);
          rsp.ready = 1'b1;
          log_q.push_back({reg_req_o.addr, reg_req_o.write,
                           reg_req_o.wdata, reg_req_o.wstrb});
          xfer_idx++;
          last_cpl_cyc = cyc;
        end else begin
          stall_run++;
          stalls++;
        end
        prev_stall = !rdy;
        prev_req   = reg_req_o;
      end else begin
        prev_stall = 1'b0;
        stall_run  = 0;
      end
      reg_rsp_i = rsp;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        err_seen = error_o;
`ifdef ASCON_DRV_CYCLE_CNT_EN
        cyc_seen = cycles_o;
`endif
      end
    end
  end

  // Reference model state.
  xfer_t exp_q [$];
  bit    exp_err;
  st_t   exp_state = '0;

  function automatic xfer_t mk(input logic [31:0] a, input bit w,
                               input logic [31:0] d);
    return {a, w, (w ? d : 32'h0), (w ? 4'hF : 4'h0)};
  endfunction

  function automatic logic [31:0] model_word(input st_t s, input int k);
    logic [63:0] lane;
    lane = s[k / 2];
    return (k % 2 == 1) ? lane[63:32] : lane[31:0];
  endfunction

  // Expected transfer list for one command: 10 writes, launch, polls, 10 reads,
  // cut short at the injected error; also updates the expected readback.
  task automatic build_expect(input st_t st, input int done_poll, input int err);
    xfer_t full [$];
    int    n;
    int    k;
    exp_q.delete();
    for (int i = 0; i < 10; i++) full.push_back(mk(BASE + 4 + 4 * i, 1'b1, model_word(st, i)));
    full.push_back(mk(BASE, 1'b1, 32'h1 << START_B));
    n = (done_poll == 0) ? LIMIT : done_poll;
    for (int i = 0; i < n; i++) full.push_back(mk(BASE, 1'b0, 32'h0));
    if (done_poll != 0)
      for (int i = 0; i < 10; i++) full.push_back(mk(BASE + 4 + 4 * i, 1'b0, 32'h0));
    exp_err = (done_poll == 0);
    for (int i = 0; i < full.size(); i++) begin
      if (err >= 0 && i > err) break;
      exp_q.push_back(full[i]);
      if (i == err) begin
        exp_err = 1'b1;
      end else if (!full[i].write && full[i].addr != BASE) begin
        k = int'((full[i].addr - BASE - 4) / 4);
        exp_state[k / 2][32 * (k % 2) +: 32] = rb[k];
      end
    end
  endtask

  task automatic run_seq(input string name, input st_t st, input int done_poll,
                         input int err, input bit waits, input bit hold);
    int  a0, d0, n;
    bool_loop: begin end
    build_expect(st, done_poll, err);
    cfg_done_poll = done_poll;
    cfg_err       = err;
    wait_en       = waits;
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clk_i); #1;
    check({name, "/ready_before"}, cmd_ready_o, 1'b1);
    state_i     = st;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    if (!hold) cmd_valid_i = 1'b0;
    state_i = {$urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    cmd_valid_i = 1'b0;
    check({name, "/done_seen"}, done_cnt - d0, 1);
    check({name, "/accepts"}, acc_cnt - a0, 1);
    check({name, "/error_o"}, err_seen, exp_err);
    check({name, "/n_xfers"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s/xfer%0d", name, i), log_q[i], exp_q[i]);
    check({name, "/state_o"}, state_o, exp_state);
    check({name, "/fin_after_last"}, done_cyc, last_cpl_cyc + 1);
    if (!exp_err)
      check({name, "/latency"}, done_cyc - acc_cyc, 22 + done_poll + stalls);
    check({name, "/ready_after"}, cmd_ready_o, 1'b1);
    check({name, "/done_pulse"}, done_o, 1'b0);
    if (waits) check({name, "/stable"}, viol, 0);
`ifdef ASCON_DRV_CYCLE_CNT_EN
    if (err < 0 || err > 10) check({name, "/cycles"}, cyc_seen, stat_cyc);
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check({name, "/quiet"}, log_q.size(), exp_q.size());
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st_t st;
    int  d0, n, dp, er;
    for (int i = 0; i < 10; i++) rb[i] = 32'hA0 + i;
    for (int j = 0; j < 5; j++) st[j] = {32'(2 * j + 1), 32'(2 * j)};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst/cmd_ready", cmd_ready_o, 1'b1);
    check("rst/valid", reg_req_o.valid, 1'b0);
    check("rst/done", done_o, 1'b0);
    check("rst/error", error_o, 1'b0);
    check("rst/state_o", state_o, '0);
    rst_n_i = 1'b1;

    run_seq("basic", st, 3, -1, 1'b0, 1'b0);
    check("basic/state0", state_o[0], 64'h0000_00A1_0000_00A0);
    check("basic/latency25", done_cyc - acc_cyc, 25);
`ifdef ASCON_DRV_CYCLE_CNT_EN
    check("basic/cycles3", cyc_seen, 3);
`endif
    run_seq("waits", st, 3, -1, 1'b1, 1'b0);
    run_seq("timeout", st, 0, -1, 1'b0, 1'b0);
    run_seq("buserr", st, 3, 5, 1'b0, 1'b0);
    run_seq("busy", st, 2, -1, 1'b0, 1'b1);

    // Reset in the middle of polling.
    cfg_done_poll = 0;
    cfg_err       = -1;
    wait_en       = 1'b0;
    d0 = done_cnt;
    @(posedge clk_i); #1;
    state_i     = st;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    n = 0;
    while (stat_cyc < 2 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("rstmid/reached_poll", stat_cyc >= 2, 1'b1);
    rst_n_i = 1'b0;
    #1;
    check("rstmid/valid", reg_req_o.valid, 1'b0);
    check("rstmid/cmd_ready", cmd_ready_o, 1'b1);
    check("rstmid/done", done_o, 1'b0);
    exp_state = '0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    check("rstmid/no_done", done_cnt, d0);
    check("rstmid/idle_valid", reg_req_o.valid, 1'b0);
    check("rstmid/idle_ready", cmd_ready_o, 1'b1);
    check("rstmid/state_o", state_o, exp_state);

    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < 5; j++) st[j] = {$urandom, $urandom};
      for (int i = 0; i < 10; i++) rb[i] = $urandom;
      dp = $urandom_range(0, LIMIT);
      er = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
      run_seq($sformatf("rand%0d", t), st, dp, er, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
